// File: rtl/pattern_detect_param.sv
// Parametrised serial pattern detector with runtime pattern/mask, overlap control and registered match pulse.
// Optional saturating match counter is enabled by defining PATTERN_CNT_EN.
module pattern_detect_param #(
   parameter int unsigned       PAT_W   = 5,
   parameter logic [PAT_W-1:0]  PAT_DEF = PAT_W'(5'b11010),
   parameter int unsigned       CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_i,
   input  logic             valid_i,
   input  logic             overlap_i,
   input  logic             cfg_load_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [PAT_W-1:0] mask_i,
`ifdef PATTERN_CNT_EN
   output logic [CNT_W-1:0] match_cnt_o,
   input  logic             clr_cnt_i,
`endif
   output logic             pattern_o
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
   localparam logic [FILL_W-1:0] ARM_AT   = FILL_W'(PAT_W - 1);

   // Elaboration guard on parameter legality
   if (PAT_W < 2 || CNT_W < 1) begin : g_param_check
      $error("pattern_detect_param: PAT_W must be >= 2 and CNT_W >= 1");
   end

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_W-2:0]   hist_q, hist_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [PAT_W-1:0]   mask_q, mask_d;
   logic [PAT_W-1:0]   window_c;
   logic               match_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= FILL;
         fill_q    <= '0;
         hist_q    <= '0;
         pat_q     <= PAT_DEF;
         mask_q    <= '1;
         pattern_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         hist_q    <= hist_d;
         pat_q     <= pat_d;
         mask_q    <= mask_d;
         pattern_o <= match_c;
      end
   end

   // Window = stored history plus the bit arriving on this edge; the first received bit lands at the MSB
   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      hist_d   = hist_q;
      pat_d    = pat_q;
      mask_d   = mask_q;
      match_c  = 1'b0;
      window_c = {hist_q, data_i};

      if (cfg_load_i) begin
         pat_d  = pattern_i;
         mask_d = mask_i;
         hist_d = '0;
         fill_d = '0;
      end else if (valid_i) begin
         hist_d = window_c[PAT_W-2:0];
         fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
         if (state_q == ARMED && ((window_c ^ pat_q) & mask_q) == '0) begin
            match_c = 1'b1;
         end
         if (match_c && !overlap_i) begin
            hist_d = '0;
            fill_d = '0;
         end
      end

      state_d = (fill_d >= ARM_AT) ? ARMED : FILL;
   end

`ifdef PATTERN_CNT_EN
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over the old value but still counts a coincident match
   always_comb begin
      cnt_d = match_cnt_o;
      if (clr_cnt_i) begin
         cnt_d = match_c ? CNT_W'(1) : '0;
      end else if (match_c && match_cnt_o != '1) begin
         cnt_d = match_cnt_o + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_cnt_o <= '0;
      end else begin
         match_cnt_o <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_pattern_detect_param.sv
// Scoreboard bench for pattern_detect_param: directed scenarios then random stream vs. a window-queue model.
module tb_pattern_detect_param;

   localparam int unsigned PAT_W   = 5;
   localparam int unsigned CNT_W   = 2;
   localparam logic [PAT_W-1:0] PAT_DEF = 5'b11010;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             data;
   logic             valid;
   logic             overlap;
   logic             cfg_load;
   logic             clr;
   logic [PAT_W-1:0] pattern;
   logic [PAT_W-1:0] mask;
   logic             pattern_o;
   logic [CNT_W-1:0] match_cnt;

   typedef struct {
      bit p;
      int cnt;
   } exp_t;

   exp_t sb[$];
   bit   m_win[$];
   logic [PAT_W-1:0] m_pat;
   logic [PAT_W-1:0] m_mask;
   int   m_cnt;
   int   checks;
   int   errors;
   int   cyc;

   pattern_detect_param #(
      .PAT_W   (PAT_W),
      .PAT_DEF (PAT_DEF),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data_i      (data),
      .valid_i     (valid),
      .overlap_i   (overlap),
      .cfg_load_i  (cfg_load),
      .pattern_i   (pattern),
      .mask_i      (mask),
`ifdef PATTERN_CNT_EN
      .match_cnt_o (match_cnt),
      .clr_cnt_i   (clr),
`endif
      .pattern_o   (pattern_o)
   );

`ifndef PATTERN_CNT_EN
   assign match_cnt = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: keep the last PAT_W accepted bits since reset/load/non-overlap hit; hit when all masked positions agree
   task automatic tick();
      exp_t e;
      bit   hit;
      hit = 1'b0;
      if (!rst) begin
         m_win.delete();
         m_pat  = PAT_DEF;
         m_mask = '1;
         m_cnt  = 0;
      end else begin
         if (cfg_load) begin
            m_pat  = pattern;
            m_mask = mask;
            m_win.delete();
         end else if (valid) begin
            m_win.push_back(bit'(data));
            if (m_win.size() > PAT_W) void'(m_win.pop_front());
            if (m_win.size() == PAT_W) begin
               hit = 1'b1;
               for (int i = 0; i < PAT_W; i++) begin
                  if (m_mask[PAT_W-1-i] && (m_win[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
               end
            end
            if (hit && !overlap) m_win.delete();
         end
         if (clr) m_cnt = hit ? 1 : 0;
         else if (hit && m_cnt < CNT_MAX) m_cnt++;
      end
      e.p   = hit;
      e.cnt = m_cnt;
      sb.push_back(e);
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic feed(input logic [31:0] bits, input int n, input bit gaps);
      for (int i = n - 1; i >= 0; i--) begin
         valid = 1'b1;
         data  = bits[i];
         tick();
         if (gaps) begin
            valid = 1'b0;
            data  = ~bits[i];
            tick();
            tick();
         end
      end
      valid = 1'b0;
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
      cfg_load = 1'b1;
      pattern  = p;
      mask     = m;
      valid    = 1'b1;
      data     = 1'b1;
      tick();
      cfg_load = 1'b0;
      valid    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: one expected entry per clock, compared on the falling edge after the DUT has updated
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (pattern_o !== e.p) begin
            errors++;
            $display("FAIL pattern_o cyc=%0d got %b exp %b", cyc, pattern_o, e.p);
         end
`ifdef PATTERN_CNT_EN
         checks++;
         if (match_cnt !== CNT_W'(e.cnt)) begin
            errors++;
            $display("FAIL match_cnt cyc=%0d got %0d exp %0d", cyc, match_cnt, e.cnt);
         end
`endif
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      rst      = 1'b0;
      data     = 1'b0;
      valid    = 1'b0;
      overlap  = 1'b1;
      cfg_load = 1'b0;
      clr      = 1'b0;
      pattern  = '0;
      mask     = '0;
      idle(3);
      rst = 1'b1;
      idle(2);

      // T1: default pattern 11010
      feed(32'b11010, 5, 1'b0);
      idle(2);

      // T2: overlapping then non-overlapping on 1010101
      load(5'b10101, 5'b11111);
      overlap = 1'b1;
      feed(32'b1010101, 7, 1'b0);
      idle(1);
      load(5'b10101, 5'b11111);
      overlap = 1'b0;
      feed(32'b1010101, 7, 1'b0);
      idle(1);

      // T3: gaps between valid bits
      load(5'b11010, 5'b11111);
      feed(32'b11010, 5, 1'b1);
      idle(1);

      // T4: don't-care in the middle position
      load(5'b11010, 5'b11011);
      feed(32'b11110, 5, 1'b0);
      feed(32'b10010, 5, 1'b0);
      idle(1);

      // T5: reset aborts a partial match
      load(5'b11010, 5'b11111);
      feed(32'b1101, 4, 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      feed(32'b0, 1, 1'b0);
      feed(32'b11010, 5, 1'b0);
      idle(1);

      // T6: counter saturation and clear coincident with a match
      overlap = 1'b1;
      load(5'b10101, 5'b11111);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      feed(32'b10101010101, 11, 1'b0);
      feed(32'b0, 1, 1'b0);
      clr = 1'b1;
      feed(32'b1, 1, 1'b0);
      clr = 1'b0;
      idle(2);

      // Degenerate all-don't-care mask
      load(5'b00000, 5'b00000);
      feed(32'b1001101, 7, 1'b0);
      idle(1);

      // Random stream
      for (int i = 0; i < 3000; i++) begin
         int r;
         rst      = 1'b1;
         cfg_load = 1'b0;
         clr      = ($urandom_range(0, 49) == 0);
         r        = $urandom_range(0, 199);
         valid    = ($urandom_range(0, 3) != 0);
         data     = 1'($urandom);
         if (r == 0) begin
            rst = 1'b0;
         end else if (r < 5) begin
            cfg_load = 1'b1;
            pattern  = PAT_W'($urandom);
            mask     = PAT_W'($urandom | $urandom);
            overlap  = 1'($urandom);
         end
         tick();
      end
      rst      = 1'b1;
      cfg_load = 1'b0;
      clr      = 1'b0;
      valid    = 1'b0;
      idle(2);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
